// File: rtl/echo_threshold_detector.sv
// echo_threshold_detector
//   Measures time-of-flight from a transmit burst to the first confirmed echo.
//   A 7-bit threshold is latched when a measurement starts and scaled into a
//   compare level. After a ringdown blanking window, the detector looks for
//   CONFIRM_N consecutive valid samples whose magnitude reaches the level.
//   The cycle stamp of the first sample in that run is reported. If the stamp
//   counter saturates first, a timeout is reported instead. The result is held
//   until the consumer acknowledges it.
// Ports
//   clk, reset_n   clock and asynchronous active-low reset
//   thresh         threshold word, latched on an accepted start
//   start          one-cycle pulse; aborts any current activity and restarts
//   sample_valid   qualifies sample
//   sample         signed ADC sample
//   tof_ack        releases a held result
//   tof_valid      result held (echo or timeout)
//   tof            cycles from start to the first sample of the confirmed run
//   timeout        1 = no echo was found; tof is then all ones
//   busy           measurement in progress
module echo_threshold_detector #(
    parameter int SAMPLE_W     = 12,
    parameter int THRESH_SHIFT = 5,
    parameter int CONFIRM_N    = 4,
    parameter int BLANK_CYCLES = 200,
    parameter int TS_W         = 24
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [6:0]                 thresh,
    input  logic                       start,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic                       tof_ack,
    output logic                       tof_valid,
    output logic [TS_W-1:0]            tof,
    output logic                       timeout,
    output logic                       busy
);

    localparam int LVL_W = 7 + THRESH_SHIFT;
    localparam int CMP_W = (LVL_W > SAMPLE_W) ? LVL_W : SAMPLE_W;
    localparam int RUN_W = $clog2(CONFIRM_N + 1);
    localparam logic [TS_W-1:0]  TS_MAX     = {TS_W{1'b1}};
    localparam logic [TS_W-1:0]  BLANK_LAST = TS_W'(BLANK_CYCLES - 1);
    localparam logic [RUN_W-1:0] RUN_ONE    = RUN_W'(1);
    localparam logic [RUN_W-1:0] RUN_TARGET = RUN_W'(CONFIRM_N);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BLANK   = 3'd1,
        ST_ARMED   = 3'd2,
        ST_CONFIRM = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Magnitude of a two's-complement sample. The most-negative code has no
    // positive counterpart, so it saturates to the largest positive magnitude.
    function automatic logic [SAMPLE_W-2:0] sat_mag(input logic [SAMPLE_W-1:0] s);
        logic [SAMPLE_W-1:0] neg_v;
        neg_v = ~s + {{(SAMPLE_W-1){1'b0}}, 1'b1};
        if (!s[SAMPLE_W-1]) begin
            sat_mag = s[SAMPLE_W-2:0];
        end else if (s[SAMPLE_W-2:0] == {(SAMPLE_W-1){1'b0}}) begin
            sat_mag = {(SAMPLE_W-1){1'b1}};
        end else begin
            sat_mag = neg_v[SAMPLE_W-2:0];
        end
    endfunction

    state_t            state_r, state_s;
    logic [TS_W-1:0]   ts_r, ts_s;
    logic [TS_W-1:0]   cand_r, cand_s;
    logic [RUN_W-1:0]  run_r, run_s;
    logic [6:0]        thr_r, thr_s;
    logic [TS_W-1:0]   tof_r, tof_s;
    logic              timeout_r, timeout_s;
    logic              tof_valid_r;
    logic              busy_r;
    logic              hit_s;
    logic [CMP_W-1:0]  level_s;
    logic [CMP_W-1:0]  mag_s;
    logic              pass_s;

    // Both operands are zero-extended to a common width, so a level above the
    // largest possible magnitude can never pass.
    assign level_s = CMP_W'({thr_r, {THRESH_SHIFT{1'b0}}});
    assign mag_s   = CMP_W'(sat_mag(sample));
    assign pass_s  = (mag_s >= level_s);

    // Next-state and next-datapath decision.
    always_comb begin
        state_s   = state_r;
        ts_s      = ts_r;
        cand_s    = cand_r;
        run_s     = run_r;
        thr_s     = thr_r;
        tof_s     = tof_r;
        timeout_s = timeout_r;
        hit_s     = 1'b0;
        if (start) begin
            // A start always wins. It discards any run or unacknowledged result.
            state_s   = ST_BLANK;
            ts_s      = {TS_W{1'b0}};
            run_s     = {RUN_W{1'b0}};
            thr_s     = thresh;
            timeout_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_BLANK: begin
                    ts_s = ts_r + {{(TS_W-1){1'b0}}, 1'b1};
                    if (ts_r == BLANK_LAST) begin
                        state_s = ST_ARMED;
                    end else begin
                        state_s = ST_BLANK;
                    end
                end
                ST_ARMED: begin
                    ts_s = ts_r + {{(TS_W-1){1'b0}}, 1'b1};
                    if (sample_valid && pass_s) begin
                        cand_s = ts_r;
                        run_s  = RUN_ONE;
                        if (CONFIRM_N == 1) begin
                            hit_s     = 1'b1;
                            tof_s     = ts_r;
                            timeout_s = 1'b0;
                            state_s   = ST_DONE;
                        end else begin
                            state_s = ST_CONFIRM;
                        end
                    end else begin
                        state_s = ST_ARMED;
                    end
                end
                ST_CONFIRM: begin
                    ts_s = ts_r + {{(TS_W-1){1'b0}}, 1'b1};
                    if (sample_valid) begin
                        if (pass_s) begin
                            run_s = run_r + RUN_ONE;
                            if ((run_r + RUN_ONE) == RUN_TARGET) begin
                                hit_s     = 1'b1;
                                tof_s     = cand_r;
                                timeout_s = 1'b0;
                                state_s   = ST_DONE;
                            end else begin
                                state_s = ST_CONFIRM;
                            end
                        end else begin
                            run_s   = {RUN_W{1'b0}};
                            state_s = ST_ARMED;
                        end
                    end else begin
                        // Gaps in the sample stream do not break a run.
                        state_s = ST_CONFIRM;
                    end
                end
                ST_DONE: begin
                    if (tof_ack) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DONE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
            // The stamp counter is exhausted. A run that confirms on this same
            // cycle still reports its echo.
            if (busy_r && !hit_s && (ts_r == TS_MAX)) begin
                state_s   = ST_DONE;
                tof_s     = TS_MAX;
                timeout_s = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            ts_r        <= {TS_W{1'b0}};
            cand_r      <= {TS_W{1'b0}};
            run_r       <= {RUN_W{1'b0}};
            thr_r       <= 7'd0;
            tof_r       <= {TS_W{1'b0}};
            timeout_r   <= 1'b0;
            tof_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            ts_r        <= ts_s;
            cand_r      <= cand_s;
            run_r       <= run_s;
            thr_r       <= thr_s;
            tof_r       <= tof_s;
            timeout_r   <= timeout_s;
            tof_valid_r <= (state_s == ST_DONE);
            busy_r      <= (state_s == ST_BLANK) || (state_s == ST_ARMED) ||
                           (state_s == ST_CONFIRM);
        end
    end

    assign tof_valid = tof_valid_r;
    assign tof       = tof_r;
    assign timeout   = timeout_r;
    assign busy      = busy_r;

endmodule
